// File: rtl/vga_frame_sched.sv
// Raster timing, per-line prefetch request scheduling and frame-boundary config
// shadowing for the VGA pattern datapath.
module vga_frame_sched #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic [7:0] cfg_in,
   input  logic       cfg_wr,
   input  logic       line_ack,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic [7:0] cfg_active,
   output logic       cfg_pending,
   output logic [7:0] frame_cnt,
   output logic       line_req,
   output logic [9:0] line_num,
   output logic       line_miss,
   output logic [7:0] miss_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {StIdle, StReq} req_state_e;

   req_state_e state;
   logic [7:0] cfg_shadow;
   logic [9:0] h_nxt, v_nxt, line_nxt;
   logic       h_last, v_last, frame_end, req_start, req_expire;

   // Syncs and display_on are computed from the next position so they stay
   // aligned with the registered hpos/vpos.
   always_comb begin
      h_last     = (hpos == H_LAST);
      v_last     = (vpos == V_LAST);
      h_nxt      = h_last ? 10'd0 : hpos + 10'd1;
      line_nxt   = v_last ? 10'd0 : vpos + 10'd1;
      v_nxt      = h_last ? line_nxt : vpos;
      frame_end  = pix_en & h_last & v_last;
      req_start  = pix_en & (h_nxt == H_VIS) & (line_nxt < V_VIS);
      req_expire = pix_en & (h_nxt == H_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hpos       <= '0;
         vpos       <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         display_on <= 1'b1;
         frame_cnt  <= '0;
      end else if (pix_en) begin
         hpos       <= h_nxt;
         vpos       <= v_nxt;
         hsync      <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
         vsync      <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
         display_on <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
         if (frame_end) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   // A write on the boundary edge still commits the older pending value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_shadow  <= '0;
         cfg_pending <= 1'b0;
         cfg_active  <= '0;
      end else begin
         if (frame_end && cfg_pending) cfg_active <= cfg_shadow;
         if (cfg_wr) begin
            cfg_shadow  <= cfg_in;
            cfg_pending <= 1'b1;
         end else if (frame_end) begin
            cfg_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         line_req  <= 1'b0;
         line_num  <= '0;
         line_miss <= 1'b0;
         miss_cnt  <= '0;
      end else begin
         line_miss <= 1'b0;
         unique case (state)
            StIdle: begin
               if (req_start) begin
                  state    <= StReq;
                  line_req <= 1'b1;
                  line_num <= line_nxt;
               end
            end
            StReq: begin
               if (line_ack) begin
                  state    <= StIdle;
                  line_req <= 1'b0;
               end else if (req_expire) begin
                  state     <= StIdle;
                  line_req  <= 1'b0;
                  line_miss <= 1'b1;
                  if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_frame_sched.sv
// Directed bench for vga_frame_sched using a reduced 25x13 raster so whole
// frames fit in a short run; expected counts are derived from that geometry.
module tb_vga_frame_sched;

   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 8, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;  // 25
   localparam int VT = VA + VF + VS + VB;  // 13
   localparam int FR = HT * VT;            // 325

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pix_en = 1'b0;
   logic [7:0] cfg_in = 8'h00;
   logic       cfg_wr = 1'b0;
   logic       line_ack = 1'b0;
   logic       hsync, vsync, display_on, cfg_pending, line_req, line_miss;
   logic [9:0] hpos, vpos, line_num;
   logic [7:0] cfg_active, frame_cnt, miss_cnt;

   int n_cmp = 0;
   int n_err = 0;

   vga_frame_sched #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .cfg_in(cfg_in), .cfg_wr(cfg_wr),
      .line_ack(line_ack), .hsync(hsync), .vsync(vsync), .display_on(display_on),
      .hpos(hpos), .vpos(vpos), .cfg_active(cfg_active), .cfg_pending(cfg_pending),
      .frame_cnt(frame_cnt), .line_req(line_req), .line_num(line_num),
      .line_miss(line_miss), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Pattern-generator model: acknowledge 5 clks after line_req rises.
   logic ack_mode = 1'b1;
   int   ack_run = 0;
   always @(negedge clk) begin
      if (ack_mode && line_req && !rst) begin
         ack_run <= ack_run + 1;
         if (ack_run == 4) line_ack <= 1'b1;
      end else begin
         ack_run  <= 0;
         line_ack <= 1'b0;
      end
   end

   // Output monitor, sampled on the falling edge.
   int hs_low, hs_falls, hs_run, hs_bad, hs_run_exp;
   int vs_low, vs_run, vs_bad, vs_run_exp, de_cnt;
   int req_cnt, req_run, req_bad, req_run_exp, line_bad, exp_line;
   int miss_seen, miss_pos_bad, miss_long, hold_chk, hold_bad;
   logic        pe_q = 1'b0;
   logic        prev_hs = 1'b1, prev_vs = 1'b1, prev_req = 1'b0, prev_miss = 1'b0;
   logic [30:0] prev_vec = '0;

   always @(posedge clk) pe_q <= pix_en;

   always @(negedge clk) begin
      if (rst) begin
         hs_run  <= 0;
         vs_run  <= 0;
         req_run <= 0;
      end else begin
         if (!hsync) begin
            hs_low <= hs_low + 1;
            hs_run <= hs_run + 1;
            if (prev_hs) hs_falls <= hs_falls + 1;
         end else if (!prev_hs) begin
            if (hs_run != hs_run_exp) hs_bad <= hs_bad + 1;
            hs_run <= 0;
         end
         if (!vsync) begin
            vs_low <= vs_low + 1;
            vs_run <= vs_run + 1;
         end else if (!prev_vs) begin
            if (vs_run != vs_run_exp) vs_bad <= vs_bad + 1;
            vs_run <= 0;
         end
         if (display_on) de_cnt <= de_cnt + 1;
         if (line_req) begin
            req_run <= req_run + 1;
            if (!prev_req) begin
               req_cnt <= req_cnt + 1;
               if (int'(line_num) != exp_line) line_bad <= line_bad + 1;
               exp_line <= (exp_line + 1) % VA;
            end
         end else if (prev_req) begin
            if (req_run != req_run_exp) req_bad <= req_bad + 1;
            req_run <= 0;
         end
         if (line_miss) begin
            miss_seen <= miss_seen + 1;
            if (int'(hpos) != HT - 1) miss_pos_bad <= miss_pos_bad + 1;
            if (prev_miss) miss_long <= miss_long + 1;
         end
         if (!pe_q) begin
            hold_chk <= hold_chk + 1;
            if ({hpos, vpos, hsync, vsync, display_on, frame_cnt} != prev_vec)
               hold_bad <= hold_bad + 1;
         end
      end
      prev_hs   <= hsync;
      prev_vs   <= vsync;
      prev_req  <= line_req;
      prev_miss <= line_miss;
      prev_vec  <= {hpos, vpos, hsync, vsync, display_on, frame_cnt};
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, " hpos"}, int'(hpos), 0);
      chk({pfx, " vpos"}, int'(vpos), 0);
      chk({pfx, " hsync"}, int'(hsync), 1);
      chk({pfx, " vsync"}, int'(vsync), 1);
      chk({pfx, " display_on"}, int'(display_on), 1);
      chk({pfx, " cfg_active"}, int'(cfg_active), 0);
      chk({pfx, " cfg_pending"}, int'(cfg_pending), 0);
      chk({pfx, " frame_cnt"}, int'(frame_cnt), 0);
      chk({pfx, " line_req"}, int'(line_req), 0);
      chk({pfx, " line_num"}, int'(line_num), 0);
      chk({pfx, " line_miss"}, int'(line_miss), 0);
      chk({pfx, " miss_cnt"}, int'(miss_cnt), 0);
   endtask

   task automatic clr_mon();
      hs_low = 0; hs_falls = 0; hs_run = 0; hs_bad = 0;
      vs_low = 0; vs_run = 0; vs_bad = 0; de_cnt = 0;
      req_cnt = 0; req_run = 0; req_bad = 0; line_bad = 0; exp_line = 1;
      miss_seen = 0; miss_pos_bad = 0; miss_long = 0; hold_chk = 0; hold_bad = 0;
   endtask

   // mode 0: pix_en high, 1: alternate starting high, 2: pix_en low.
   task automatic step(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       pix_en = 1'b1;
            1:       pix_en = (i % 2 == 0);
            default: pix_en = 1'b0;
         endcase
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic write_cfg(input logic [7:0] val, input int mode);
      cfg_in = val;
      cfg_wr = 1'b1;
      step(1, mode);
      cfg_wr = 1'b0;
   endtask

   initial begin
      hs_run_exp = HS; vs_run_exp = VS * HT; req_run_exp = 5;
      clr_mon();
      #1 rst = 1'b1;
      #2 chk_reset("por");
      @(posedge clk);
      #1 rst = 1'b0;

      // Continuous pix_en, acked requests, three frames.
      clr_mon();
      step(3 * FR - 1, 0);
      chk("t1 frame_cnt pre", int'(frame_cnt), 2);
      chk("t1 hpos pre", int'(hpos), HT - 1);
      chk("t1 vpos pre", int'(vpos), VT - 1);
      step(1, 0);
      chk("t1 frame_cnt", int'(frame_cnt), 3);
      chk("t1 hpos wrap", int'(hpos), 0);
      chk("t1 vpos wrap", int'(vpos), 0);
      chk("t1 hsync falls", hs_falls, 3 * VT);
      chk("t1 hsync low clks", hs_low, 3 * VT * HS);
      chk("t1 hsync run bad", hs_bad, 0);
      chk("t1 vsync low clks", vs_low, 3 * VS * HT);
      chk("t1 vsync run bad", vs_bad, 0);
      chk("t1 display clks", de_cnt, 3 * HA * VA);
      chk("t1 req count", req_cnt, 3 * VA);
      chk("t1 line order bad", line_bad, 0);
      chk("t1 req width bad", req_bad, 0);
      chk("t1 misses", miss_seen, 0);

      // pix_en every other clk: widths double, state holds while low.
      do_reset();
      clr_mon();
      hs_run_exp = 2 * HS; vs_run_exp = 2 * VS * HT;
      step(6 * FR - 2, 1);
      chk("t2 frame_cnt pre", int'(frame_cnt), 2);
      chk("t2 hpos pre", int'(hpos), HT - 1);
      step(2, 1);
      chk("t2 frame_cnt", int'(frame_cnt), 3);
      chk("t2 hpos wrap", int'(hpos), 0);
      chk("t2 hsync falls", hs_falls, 3 * VT);
      chk("t2 hsync low clks", hs_low, 6 * VT * HS);
      chk("t2 hsync run bad", hs_bad, 0);
      chk("t2 vsync low clks", vs_low, 6 * VS * HT);
      chk("t2 vsync run bad", vs_bad, 0);
      chk("t2 display clks", de_cnt, 6 * HA * VA);
      chk("t2 hold samples", hold_chk, 3 * FR - 1);
      chk("t2 hold bad", hold_bad, 0);
      chk("t2 req count", req_cnt, 3 * VA);
      chk("t2 line order bad", line_bad, 0);
      chk("t2 req width bad", req_bad, 0);

      // Config shadowing across frame boundaries.
      do_reset();
      clr_mon();
      hs_run_exp = HS; vs_run_exp = VS * HT;
      step(50, 0);
      write_cfg(8'h5A, 0);
      chk("t3 pending 5A", int'(cfg_pending), 1);
      chk("t3 active 5A", int'(cfg_active), 0);
      step(3, 0);
      write_cfg(8'h3C, 0);
      chk("t3 active 3C", int'(cfg_active), 0);
      step(FR - 1 - 55, 0);
      chk("t3 active pre-boundary", int'(cfg_active), 0);
      chk("t3 pending pre-boundary", int'(cfg_pending), 1);
      write_cfg(8'h77, 0);
      chk("t3 active boundary", int'(cfg_active), 8'h3C);
      chk("t3 pending boundary", int'(cfg_pending), 1);
      chk("t3 frame_cnt boundary", int'(frame_cnt), 1);
      step(FR - 1, 0);
      chk("t3 active mid", int'(cfg_active), 8'h3C);
      step(1, 0);
      chk("t3 active 77", int'(cfg_active), 8'h77);
      chk("t3 pending clear", int'(cfg_pending), 0);
      write_cfg(8'hA5, 2);
      chk("t3 pending no pix_en", int'(cfg_pending), 1);
      chk("t3 hpos frozen", int'(hpos), 0);

      // No acknowledge: every request expires; miss_cnt saturates.
      ack_mode = 1'b0;
      do_reset();
      clr_mon();
      req_run_exp = HT - 1 - HA;
      write_cfg(8'hC3, 2);
      step(FR, 0);
      chk("t4 miss_cnt f1", int'(miss_cnt), VA);
      chk("t4 miss pulses f1", miss_seen, VA);
      chk("t4 miss pos bad", miss_pos_bad, 0);
      chk("t4 miss long", miss_long, 0);
      chk("t4 req width bad", req_bad, 0);
      chk("t4 cfg_active", int'(cfg_active), 8'hC3);
      step(30 * FR, 0);
      chk("t4 miss_cnt f31", int'(miss_cnt), 31 * VA);
      step(FR, 0);
      chk("t4 miss_cnt sat", int'(miss_cnt), 255);
      chk("t4 miss pulses", miss_seen, 32 * VA);
      chk("t4 miss pos bad end", miss_pos_bad, 0);
      chk("t4 line order bad", line_bad, 0);

      // Asynchronous reset with an outstanding request.
      write_cfg(8'h11, 2);
      step(3 * HT + 20, 0);
      chk("t5 line_req pre", int'(line_req), 1);
      chk("t5 line_num pre", int'(line_num), 4);
      chk("t5 hpos pre", int'(hpos), 20);
      chk("t5 vpos pre", int'(vpos), 3);
      miss_seen = 0;
      rst = 1'b1;
      #1 chk_reset("async");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("t5 miss during rst", miss_seen, 0);
      step(1, 0);
      chk("t5 hpos restart", int'(hpos), 1);
      chk("t5 vpos restart", int'(vpos), 0);
      chk("t5 line_miss", int'(line_miss), 0);
      chk("t5 miss_cnt", int'(miss_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
